crc_frame_appender: RTL and testbench
=====================================

# crc_frame_appender

Byte-stream framing stage that sits directly in front of the CRC calculator. It forwards each frame from an upstream valid/ready/last stream to a downstream stream and drives the calculator's soft-reset, valid and data inputs with every accepted byte. When a frame ends, it samples the calculator's CRC output, appends it as CRC_SIZE/8 trailing bytes, and re-arms the calculator for the next frame.

## Interface
- CRC_SIZE, 16, CRC width in bits; must be a multiple of 8 (8..64).
- CRC_LSB_FIRST, 1, 1: append the CRC least-significant byte first (reflected CRCs); 0: most-significant byte first.
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- s_data_i  input  8  upstream byte.
- s_valid_i  input  1  upstream byte valid.
- s_last_i  input  1  the byte is the final payload byte of its frame.
- s_ready_o  output  1  the block accepts the upstream byte this cycle.
- m_data_o  output  8  downstream byte (payload or CRC).
- m_valid_o  output  1  downstream byte valid.
- m_last_o  output  1  the byte is the final CRC byte of its frame.
- m_ready_i  input  1  downstream accepts the byte.
- crc_soft_reset_o  output  1  calculator soft reset.
- crc_valid_o  output  1  calculator data valid; equals s_valid_i && s_ready_o.
- crc_data_o  output  8  calculator data; equals s_data_i.
- crc_i  input  CRC_SIZE  registered CRC output of the calculator, including final XOR.

## Operation
- **Handshakes:** a transfer occurs on a cycle where valid and ready are both high. The output is a single register slot (m_data_o, m_valid_o, m_last_o). The slot is free when `!m_valid_o || m_ready_i`.
- **INIT:** entered on reset.
  - s_ready_o = 0 and crc_soft_reset_o = 1 for exactly one cycle.
  - Then go to PASS.
- **PASS:**
  - s_ready_o = slot free.
  - Each accepted byte is loaded into the slot with m_last_o = 0.
  - The accepted byte is also presented to the calculator through crc_valid_o / crc_data_o.
  - An accepted byte with s_last_i = 1 moves the state to CAPTURE.
- **CAPTURE:** lasts one cycle.
  - s_ready_o = 0.
  - crc_i already includes the last byte, because the calculator registers it on the accept edge.
  - Latch crc_i into the CRC shift register and set byte counter = CRC_SIZE/8.
  - Assert crc_soft_reset_o.
  - Go to APPEND.
- **APPEND:**
  - s_ready_o = 0.
  - Each time the slot is free, load the next CRC byte: `crc_sh[7:0]` then shift right when LSB-first; `crc_sh[CRC_SIZE-1 -: 8]` then shift left when MSB-first.
  - Decrement the counter on each load.
  - The load with counter = 1 sets m_last_o = 1 and returns to PASS.
- **Frame boundaries:** a frame of one byte is legal. Back-to-back frames are legal. No frame-length limit.
- **Unsupported:** s_last_i on a frame with zero payload bytes is not supported (no empty frames).
- **Reset:**
  - All registers clear asynchronously: m_valid_o = 0, m_last_o = 0, m_data_o = 0, crc_sh = 0, counter = 0, state = INIT.
  - crc_soft_reset_o = 1 while rst_n_i is low and during INIT.
  - A reset mid-frame discards the partial frame. The calculator is re-armed by INIT.

## Timing
- Payload latency is 1 cycle from the accept edge to m_valid_o.
- The per-frame overhead is a 1-cycle bubble (CAPTURE) plus CRC_SIZE/8 CRC byte cycles. The first CRC byte is loaded in the cycle after CAPTURE, provided the slot is free.
- With m_ready_i held high, throughput in PASS is one byte per cycle.
- Downstream backpressure:
  - The slot holds its data.
  - s_ready_o drops in the same cycle.
  - The calculator sees no valid byte.
- m_ready_i is never used combinationally to drive m_valid_o or m_data_o. s_ready_o does depend combinationally on m_ready_i.

## Configuration
- **CRC_FRAME_APPENDER_CNT_EN defined:**
  - Adds the output frame_cnt_o, 32 bits wide.
  - It increments on each downstream transfer with m_last_o = 1 and saturates at 0xFFFF_FFFF.
  - It is cleared to 0 by reset.
- **CRC_FRAME_APPENDER_CNT_EN undefined:** the port and its logic are absent, and behaviour is otherwise identical.

## Test plan
- CRC-16/ARC calculator (POLY 8005, INIT 0, REF_IN/REF_OUT TRUE, XOR_OUT 0), CRC_LSB_FIRST = 1, frame "123456789", m_ready_i = 1 -> output is the 9 payload bytes, then 0x3D, then 0xBB with m_last_o = 1; crc_soft_reset_o pulses once in CAPTURE.
- CRC-32 calculator (CRC_SIZE 32), same frame -> 0x26, 0x39, 0xF4, 0xCB appended; the last byte has m_last_o = 1; CRC_LSB_FIRST = 0 gives 0xCB, 0xF4, 0x39, 0x26.
- Two back-to-back frames, "123456789" twice -> both frames carry 0xBB3D. This proves the soft reset between frames.
- Random m_ready_i (50 % duty) and random gaps in s_valid_i -> byte stream identical to the m_ready_i = 1 case; m_data_o/m_valid_o stay stable while stalled.
- rst_n_i pulsed low after 4 bytes of a frame -> m_valid_o = 0 immediately; the following full "123456789" frame yields 0xBB3D.
- With CRC_FRAME_APPENDER_CNT_EN, send 3 frames -> frame_cnt_o = 3 after the third m_last_o transfer, and 0 after reset.

Source files
------------

// File: rtl/crc_frame_appender.sv
// rtl/crc_frame_appender.sv - forwards byte frames and appends the calculator CRC as trailing bytes
// Optional feature: define CRC_FRAME_APPENDER_CNT_EN to add the 32-bit saturating frame_cnt_o output.
module crc_frame_appender #(
    parameter int CRC_SIZE      = 16,
    parameter bit CRC_LSB_FIRST = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [7:0]          s_data_i,
    input  logic                s_valid_i,
    input  logic                s_last_i,
    output logic                s_ready_o,
    output logic [7:0]          m_data_o,
    output logic                m_valid_o,
    output logic                m_last_o,
    input  logic                m_ready_i,
    output logic                crc_soft_reset_o,
    output logic                crc_valid_o,
    output logic [7:0]          crc_data_o,
`ifdef CRC_FRAME_APPENDER_CNT_EN
    output logic [31:0]         frame_cnt_o,
`endif
    input  logic [CRC_SIZE-1:0] crc_i
);

    localparam logic [3:0] NBYTES = 4'(CRC_SIZE / 8);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_PASS,
        ST_CAPTURE,
        ST_APPEND
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                slot_free;
    logic                accept;
    logic                load_crc;
    logic [7:0]          crc_byte;
    logic [CRC_SIZE-1:0] crc_sh;
    logic [3:0]          cnt;

    // The output slot can take a new byte when empty or being drained this cycle.
    assign slot_free   = !m_valid_o || m_ready_i;
    assign s_ready_o   = (state == ST_PASS) && slot_free;
    assign accept      = s_valid_i && s_ready_o;
    assign load_crc    = (state == ST_APPEND) && slot_free;
    assign crc_byte    = CRC_LSB_FIRST ? crc_sh[7:0] : crc_sh[CRC_SIZE-1 -: 8];
    assign crc_valid_o = accept;
    assign crc_data_o  = s_data_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; the calculator is held in soft reset during reset, INIT and CAPTURE.
    always_comb begin
        state_nxt        = state;
        crc_soft_reset_o = !rst_n_i;
        case (state)
            ST_INIT: begin
                crc_soft_reset_o = 1'b1;
                state_nxt        = ST_PASS;
            end
            ST_PASS: begin
                if (accept && s_last_i) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                crc_soft_reset_o = 1'b1;
                state_nxt        = ST_APPEND;
            end
            ST_APPEND: begin
                if (load_crc && (cnt == 4'd1)) begin
                    state_nxt = ST_PASS;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Output slot: payload bytes in PASS, CRC bytes in APPEND, otherwise drain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_data_o  <= 8'h00;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end else if (accept) begin
            m_data_o  <= s_data_i;
            m_valid_o <= 1'b1;
            m_last_o  <= 1'b0;
        end else if (load_crc) begin
            m_data_o  <= crc_byte;
            m_valid_o <= 1'b1;
            m_last_o  <= (cnt == 4'd1);
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end
    end

    // CRC shift register and remaining-byte counter; the CRC is sampled in CAPTURE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_sh <= '0;
            cnt    <= 4'd0;
        end else if (state == ST_CAPTURE) begin
            crc_sh <= crc_i;
            cnt    <= NBYTES;
        end else if (load_crc) begin
            crc_sh <= CRC_LSB_FIRST ? (crc_sh >> 8) : (crc_sh << 8);
            cnt    <= cnt - 4'd1;
        end
    end

`ifdef CRC_FRAME_APPENDER_CNT_EN
    // Count completed downstream frames, saturating at all ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_cnt_o <= 32'd0;
        end else if (m_valid_o && m_ready_i && m_last_o && (frame_cnt_o != 32'hFFFF_FFFF)) begin
            frame_cnt_o <= frame_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crc_frame_appender.sv
// tb/tb_crc_frame_appender.sv - randomized self-checking bench for crc_frame_appender
module tb_crc_frame_appender;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b0;
    logic       sel     = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last  = 1'b0;
    logic       m_ready = 1'b1;
    bit         rand_ready = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int soft_cnt    = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int         got_cyc[$];
    bq_t        known;

    // DUT A: CRC-16/ARC, LSB first. DUT B: CRC-32, MSB first.
    logic        va, vb;
    logic        sr_a, mv_a, ml_a, soft_a, cv_a;
    logic [7:0]  md_a, cd_a;
    logic [15:0] calc_a;
    logic        sr_b, mv_b, ml_b, soft_b, cv_b;
    logic [7:0]  md_b, cd_b;
    logic [31:0] calc_b, crc_b;
`ifdef CRC_FRAME_APPENDER_CNT_EN
    logic [31:0] fc_a, fc_b;
`endif

    assign va    = s_valid & ~sel;
    assign vb    = s_valid & sel;
    assign crc_b = ~calc_b;

    crc_frame_appender #(.CRC_SIZE(16), .CRC_LSB_FIRST(1'b1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .s_data_i(s_data), .s_valid_i(va), .s_last_i(s_last),
        .s_ready_o(sr_a), .m_data_o(md_a), .m_valid_o(mv_a), .m_last_o(ml_a), .m_ready_i(m_ready),
        .crc_soft_reset_o(soft_a), .crc_valid_o(cv_a), .crc_data_o(cd_a),
`ifdef CRC_FRAME_APPENDER_CNT_EN
        .frame_cnt_o(fc_a),
`endif
        .crc_i(calc_a));

    crc_frame_appender #(.CRC_SIZE(32), .CRC_LSB_FIRST(1'b0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .s_data_i(s_data), .s_valid_i(vb), .s_last_i(s_last),
        .s_ready_o(sr_b), .m_data_o(md_b), .m_valid_o(mv_b), .m_last_o(ml_b), .m_ready_i(m_ready),
        .crc_soft_reset_o(soft_b), .crc_valid_o(cv_b), .crc_data_o(cd_b),
`ifdef CRC_FRAME_APPENDER_CNT_EN
        .frame_cnt_o(fc_b),
`endif
        .crc_i(crc_b));

    function automatic logic [15:0] arc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Calculator models: registered CRC, soft reset has priority over data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) calc_a <= 16'h0000;
        else if (soft_a) calc_a <= 16'h0000;
        else if (cv_a) calc_a <= arc_step(calc_a, cd_a);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) calc_b <= 32'hFFFF_FFFF;
        else if (soft_b) calc_b <= 32'hFFFF_FFFF;
        else if (cv_b) calc_b <= crc32_step(calc_b, cd_b);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Whole-frame reference CRC, bit-serial over the message.
    function automatic logic [31:0] ref_crc(input bq_t f, input bit is32);
        logic [31:0] c, poly;
        logic        fb;
        c    = is32 ? 32'hFFFF_FFFF : 32'h0;
        poly = is32 ? 32'hEDB88320 : 32'h0000A001;
        foreach (f[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ f[i][b];
                c  = c >> 1;
                if (fb) c = c ^ poly;
            end
        end
        return is32 ? ~c : c;
    endfunction

    task automatic add_expected(input bq_t f, input bit is32);
        logic [31:0] c;
        int          n, idx;
        c = ref_crc(f, is32);
        n = is32 ? 4 : 2;
        foreach (f[i]) exp_q.push_back({1'b0, f[i]});
        for (int k = 0; k < n; k++) begin
            idx = is32 ? (n - 1 - k) : k;
            exp_q.push_back({k == n - 1, 8'(c >> (8 * idx))});
        end
    endtask

    // Monitor: collect transfers, check stall stability and calculator strobes.
    logic       stalled = 1'b0;
    logic [7:0] pd;
    logic       pl;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            vectors++;
            if (cv_a !== (va && sr_a) || cv_b !== (vb && sr_b) || cd_a !== s_data || cd_b !== s_data) begin
                miscompares++;
                $display("FAIL crc_strobe: cv_a=%b cv_b=%b cd_a=%h cd_b=%h expected valid&&ready, data=%h", cv_a, cv_b, cd_a, cd_b, s_data);
            end
            if (stalled) begin
                vectors++;
                if ((sel ? mv_b : mv_a) !== 1'b1 || (sel ? md_b : md_a) !== pd || (sel ? ml_b : ml_a) !== pl) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b", sel ? mv_b : mv_a, sel ? md_b : md_a, sel ? ml_b : ml_a, pd, pl);
                end
            end
            stalled = (sel ? mv_b : mv_a) && !m_ready;
            pd = sel ? md_b : md_a;
            pl = sel ? ml_b : ml_a;
            if ((sel ? mv_b : mv_a) && m_ready) begin
                got_q.push_back({sel ? ml_b : ml_a, sel ? md_b : md_a});
                got_cyc.push_back(cyc);
            end
            if (sel ? soft_b : soft_a) soft_cnt++;
        end
    end

    task automatic send_frame(input bq_t f, input bit with_last, input bit gaps);
        int t;
        foreach (f[i]) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = f[i];
            s_last  = with_last && (i == f.size() - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(sel ? sr_b : sr_a) && t < 500);
            if (t >= 500) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: s_ready low for %0d cycles, expected accept", t);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_stream(input string name, input int span);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s_len: got %0d bytes expected %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++;
            if (got_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s_byte%0d: got last=%b data=%h expected last=%b data=%h", name, i, got_q[i][8], got_q[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
        if (span >= 0 && got_cyc.size() > 0) begin
            vectors++;
            if (got_cyc[$] - got_cyc[0] != span) begin
                miscompares++;
                $display("FAIL %s_span: got %0d cycles expected %0d", name, got_cyc[$] - got_cyc[0], span);
            end
        end
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_known16();
        foreach (known[i]) exp_q.push_back({1'b0, known[i]});
        exp_q.push_back({1'b0, 8'h3D});
        exp_q.push_back({1'b1, 8'hBB});
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mv_a !== 1'b0 || ml_a !== 1'b0 || md_a !== 8'h00 || soft_a !== 1'b1 || sr_a !== 1'b0 || mv_b !== 1'b0 || soft_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: v=%b l=%b d=%h soft=%b rdy=%b vb=%b softb=%b expected 0 0 00 1 0 0 1", mv_a, ml_a, md_a, soft_a, sr_a, mv_b, soft_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (sr_a !== 1'b0 || soft_a !== 1'b1) begin
            miscompares++;
            $display("FAIL init_cycle: s_ready=%b soft=%b expected 0 1", sr_a, soft_a);
        end
        @(negedge clk);
        vectors++;
        if (sr_a !== 1'b1 || soft_a !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_entry: s_ready=%b soft=%b expected 1 0", sr_a, soft_a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_check_vector();
        sel = 1'b0;
        rand_ready = 1'b0;
        soft_cnt = 0;
        push_known16();
        send_frame(known, 1'b1, 1'b0);
        check_stream("arc16", 11);
        vectors++;
        if (soft_cnt != 1) begin
            miscompares++;
            $display("FAIL arc16_soft_pulses: got %0d expected 1", soft_cnt);
        end
    endtask

    task automatic test_crc32();
        sel = 1'b1;
        rand_ready = 1'b0;
        foreach (known[i]) exp_q.push_back({1'b0, known[i]});
        exp_q.push_back({1'b0, 8'hCB});
        exp_q.push_back({1'b0, 8'hF4});
        exp_q.push_back({1'b0, 8'h39});
        exp_q.push_back({1'b1, 8'h26});
        send_frame(known, 1'b1, 1'b0);
        check_stream("crc32_msb", 13);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        rand_ready = 1'b0;
        soft_cnt = 0;
        push_known16();
        push_known16();
        send_frame(known, 1'b1, 1'b0);
        send_frame(known, 1'b1, 1'b0);
        check_stream("b2b", 23);
        vectors++;
        if (soft_cnt != 2) begin
            miscompares++;
            $display("FAIL b2b_soft_pulses: got %0d expected 2", soft_cnt);
        end
    endtask

    task automatic test_random();
        bq_t f;
        rand_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            sel = 1'($urandom_range(0, 1));
            f.delete();
            repeat ($urandom_range(1, 16)) f.push_back(8'($urandom));
            if (n == 0) f = known;
            add_expected(f, sel);
            send_frame(f, 1'b1, 1'b1);
            check_stream(sel ? "rand32" : "rand16", -1);
        end
        rand_ready = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        bq_t f;
        sel = 1'b0;
        rand_ready = 1'b0;
        f = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_frame(f, 1'b0, 1'b0);
        vectors++;
        if (mv_a !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre_valid: got %b expected 1", mv_a);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mv_a !== 1'b0 || ml_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_valid: got v=%b l=%b expected 0 0", mv_a, ml_a);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
        push_known16();
        send_frame(known, 1'b1, 1'b0);
        check_stream("after_reset", 11);
    endtask

`ifdef CRC_FRAME_APPENDER_CNT_EN
    task automatic test_frame_cnt();
        bq_t f;
        do_reset();
        sel = 1'b0;
        rand_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            f.delete();
            repeat ($urandom_range(1, 6)) f.push_back(8'($urandom));
            add_expected(f, 1'b0);
            send_frame(f, 1'b1, 1'b1);
            check_stream("cnt_frame", -1);
        end
        rand_ready = 1'b0;
        vectors++;
        if (fc_a !== 32'd3 || fc_b !== 32'd0) begin
            miscompares++;
            $display("FAIL frame_cnt: got a=%0d b=%0d expected 3 0", fc_a, fc_b);
        end
        do_reset();
        vectors++;
        if (fc_a !== 32'd0) begin
            miscompares++;
            $display("FAIL frame_cnt_reset: got %0d expected 0", fc_a);
        end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        known = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        repeat (2) @(posedge clk);
        test_reset();
        test_check_vector();
        test_crc32();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef CRC_FRAME_APPENDER_CNT_EN
        test_frame_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
